// File: rtl/seq_window_if.sv
// Interface bundling the configuration, serial-input and status signals of
// seq_window_ctrl. The controller connects through the slave modport; the
// configuration/stream side uses the master modport.
interface seq_window_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             start;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] win_len;
  logic             x_valid;
  logic             x;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;

  modport master (
    output start, pat, pat_len, win_len, x_valid, x,
    input  busy, match, match_cnt, done
  );

  modport slave (
    input  start, pat, pat_len, win_len, x_valid, x,
    output busy, match, match_cnt, done
  );
endinterface

// File: rtl/seq_window_ctrl.sv
// Windowed serial pattern detector. On an accepted start it latches the
// pattern, its length and the window length, then consumes win_len valid bits
// of x, pulsing match on every completed pattern and counting matches. done
// pulses for one cycle when the window closes.
// All state advances on the falling edge of clk; clr is an asynchronous,
// active-low reset.
// Optional feature macro: NON_OVERLAP_EN -- when defined, a match clears the
// shift register so the next match needs a full pattern of fresh bits.
module seq_window_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        clr,
  seq_window_if.slave bus
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // Latched window configuration
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_win;

  // Window progress
  logic [PAT_W-1:0] r_sr;
  logic [LEN_W-1:0] r_since;      // bits since start/last clear, saturates at PAT_W
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_match;

  logic [LEN_W-1:0] w_len_eff;
  logic [PAT_W-1:0] w_mask;
  logic [PAT_W-1:0] w_sr_next;
  logic [LEN_W-1:0] w_since_next;
  logic [CNT_W-1:0] w_bit_cnt_next;
  logic             w_take;
  logic             w_last;
  logic             w_hit;

  // Effective pattern length: zero means one bit, oversize clamps to PAT_W
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    w_len_eff = bus.pat_len;
    if (bus.pat_len == '0) begin
      w_len_eff = LEN_W'(1);
    end else if (bus.pat_len > LEN_W'(PAT_W)) begin
      w_len_eff = LEN_W'(PAT_W);
    end
  end

  // Compare mask covering the low r_len bits of the shift register
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_take         = (r_state == S_RUN) && bus.x_valid;
  assign w_sr_next      = {r_sr[PAT_W-2:0], bus.x};
  assign w_since_next   = (r_since == LEN_W'(PAT_W)) ? r_since : r_since + 1'b1;
  assign w_bit_cnt_next = r_bit_cnt + 1'b1;
  assign w_last         = w_take && (w_bit_cnt_next == r_win);
  assign w_hit          = w_take && (w_since_next >= r_len) &&
                          ((w_sr_next & w_mask) == (r_pat & w_mask));

  // State register
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.win_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: configuration latch, shift register, counters and match pulse
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      // NOTE: configuration registers are reset too, so nothing ever reads an undefined pattern or length.
      r_pat       <= '0;
      r_len       <= '0;
      r_win       <= '0;
      r_sr        <= '0;
      r_since     <= '0;
      r_bit_cnt   <= '0;
      r_match_cnt <= '0;
      r_match     <= 1'b0;
    end else begin
      r_match <= w_hit;
      if ((r_state == S_IDLE) && bus.start) begin
        r_pat       <= bus.pat;
        r_len       <= w_len_eff;
        r_win       <= bus.win_len;
        r_sr        <= '0;
        r_since     <= '0;
        r_bit_cnt   <= '0;
        r_match_cnt <= '0;
      end else if (w_take) begin
        r_bit_cnt <= w_bit_cnt_next;
        if (w_hit) begin
          r_match_cnt <= r_match_cnt + 1'b1;
        end
`ifdef NON_OVERLAP_EN
        if (w_hit) begin
          r_sr    <= '0;
          r_since <= '0;
        end else begin
          r_sr    <= w_sr_next;
          r_since <= w_since_next;
        end
`else
        r_sr    <= w_sr_next;
        r_since <= w_since_next;
`endif
      end
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.match     = r_match;
  assign bus.match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_window_ctrl.sv
// Self-checking bench for seq_window_ctrl. The DUT updates on the falling
// edge; the bench drives inputs and samples outputs on the rising edge.
// Expected counts follow NON_OVERLAP_EN when the bench is built with it.
module tb_seq_window_ctrl;

`ifdef NON_OVERLAP_EN
  localparam bit NOV = 1'b1;
`else
  localparam bit NOV = 1'b0;
`endif

  typedef struct {
    logic       start;
    logic [3:0] pat;
    logic [2:0] plen;
    logic [7:0] win;
    logic       xv;
    logic       x;
    logic       busy;
    logic       match;
    logic [7:0] cnt;
    logic       done;
  } vec_t;

  logic   clk;
  logic   clr;
  vec_t   vecs[$];
  int     n_total;
  int     n_pass;

  seq_window_if #(.PAT_W(4), .CNT_W(8)) bus ();

  seq_window_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic [3:0] p, input logic [2:0] l, input logic [7:0] w,
                     input logic xv, input logic x, input logic b, input logic m,
                     input logic [7:0] c, input logic d);
    vec_t v;
    v.start = s;  v.pat = p;   v.plen = l;  v.win = w;
    v.xv    = xv; v.x   = x;   v.busy = b;  v.match = m;
    v.cnt   = c;  v.done = d;
    vecs.push_back(v);
  endtask

  // Advance one DUT update edge and return to the sampling edge
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic drive(input logic s, input logic [3:0] p, input logic [2:0] l,
                       input logic [7:0] w, input logic xv, input logic x);
    bus.start = s; bus.pat = p; bus.pat_len = l; bus.win_len = w;
    bus.x_valid = xv; bus.x = x;
  endtask

  task automatic check_outs(input string tag, input logic b, input logic m,
                            input logic [7:0] c, input logic d);
    check({tag, " busy"},      32'(bus.busy),      32'(b));
    check({tag, " match"},     32'(bus.match),     32'(m));
    check({tag, " match_cnt"}, 32'(bus.match_cnt), 32'(c));
    check({tag, " done"},      32'(bus.done),      32'(d));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clr = 1'b0;
    drive(0, 4'h0, 3'd0, 8'd0, 0, 0);

    // Pattern 1011, L=4, window 7, overlapping second match on bit 7
    add(1, 4'b1011, 3'd4, 8'd7, 0, 0,  1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 0,     1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 1, 8'd1, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 0,     1, 0, 8'd1, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 0, 8'd1, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     0, !NOV, NOV ? 8'd1 : 8'd2, 1);
    add(0, 4'h0, 3'd0, 8'd0, 0, 0,     0, 0, NOV ? 8'd1 : 8'd2, 0);
    // Pattern 00, L=2, window 4 of zeros
    add(1, 4'b0000, 3'd2, 8'd4, 0, 0,  1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 0,     1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 0,     1, 1, 8'd1, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 0,     1, !NOV, NOV ? 8'd1 : 8'd2, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 0,     0, 1, NOV ? 8'd2 : 8'd3, 1);
    add(0, 4'h0, 3'd0, 8'd0, 0, 0,     0, 0, NOV ? 8'd2 : 8'd3, 0);
    // Zero-length window: straight to DONE, count cleared
    add(1, 4'b0001, 3'd1, 8'd0, 0, 0,  0, 0, 8'd0, 1);
    add(0, 4'h0, 3'd0, 8'd0, 0, 0,     0, 0, 8'd0, 0);
    // pat_len=0 treated as 1, gaps between valid bits, x=1,0,1,1,0
    add(1, 4'b0001, 3'd0, 8'd5, 0, 0,  1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 1, 8'd1, 0);
    add(0, 4'h0, 3'd0, 8'd0, 0, 1,     1, 0, 8'd1, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 0,     1, 0, 8'd1, 0);
    add(0, 4'h0, 3'd0, 8'd0, 0, 1,     1, 0, 8'd1, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 1, 8'd2, 0);
    add(0, 4'h0, 3'd0, 8'd0, 0, 0,     1, 0, 8'd2, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 1, 8'd3, 0);
    add(0, 4'h0, 3'd0, 8'd0, 0, 1,     1, 0, 8'd3, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 0,     0, 0, 8'd3, 1);
    add(0, 4'h0, 3'd0, 8'd0, 0, 0,     0, 0, 8'd3, 0);
    // pat_len=7 clamps to 4: 1111 matches only once all four bits are in
    add(1, 4'b1111, 3'd7, 8'd4, 0, 0,  1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     0, 1, 8'd1, 1);
    add(0, 4'h0, 3'd0, 8'd0, 0, 0,     0, 0, 8'd1, 0);
    // start mid-RUN (with win_len=0) is ignored; window of 3 completes
    add(1, 4'b1011, 3'd4, 8'd3, 0, 0,  1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     1, 0, 8'd0, 0);
    add(1, 4'b0000, 3'd1, 8'd0, 1, 0,  1, 0, 8'd0, 0);
    add(0, 4'h0, 3'd0, 8'd0, 1, 1,     0, 0, 8'd0, 1);
    add(0, 4'h0, 3'd0, 8'd0, 0, 0,     0, 0, 8'd0, 0);

    // Reset state
    @(posedge clk);
    check_outs("reset", 0, 0, 8'd0, 0);
    clr = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].pat, vecs[i].plen, vecs[i].win, vecs[i].xv, vecs[i].x);
      tick();
      check_outs($sformatf("row%0d", i), vecs[i].busy, vecs[i].match, vecs[i].cnt, vecs[i].done);
    end

    // Reset mid-window after 3 of 7 bits
    drive(1, 4'b0001, 3'd1, 8'd7, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'h0, 3'd0, 8'd0, 1, 1);
      tick();
    end
    check_outs("pre_clr", 1, 1, 8'd3, 0);
    drive(0, 4'h0, 3'd0, 8'd0, 0, 0);
    clr = 1'b0;
    #1;
    check_outs("clr_async", 0, 0, 8'd0, 0);
    tick();
    check_outs("clr_held", 0, 0, 8'd0, 0);
    clr = 1'b1;

    // Fresh window after reset: 1011 in a window of 4
    drive(1, 4'b1011, 3'd4, 8'd4, 0, 0);
    tick();
    check_outs("fresh_start", 1, 0, 8'd0, 0);
    drive(0, 4'h0, 3'd0, 8'd0, 1, 1); tick();
    drive(0, 4'h0, 3'd0, 8'd0, 1, 0); tick();
    drive(0, 4'h0, 3'd0, 8'd0, 1, 1); tick();
    drive(0, 4'h0, 3'd0, 8'd0, 1, 1); tick();
    check_outs("fresh_last", 0, 1, 8'd1, 1);
    drive(0, 4'h0, 3'd0, 8'd0, 0, 0); tick();
    check_outs("fresh_idle", 0, 0, 8'd1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
